regalu_pipe: RTL and testbench

Parametrised successor to the single-cycle register-file/ALU datapath. It is a two-stage issue/execute unit: a multi-ported register file feeds an operand-forwarding execute stage that supports 8 ALU operations, including an iterative multi-cycle multiply. It has a valid/ready issue handshake, a busy stall during multiply, and an external preload write port. It sits between decode and the branch/writeback logic of the CPU core, and exposes a0 for test observation.

---
 rtl/regalu_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_regalu_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regalu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : regalu_pipe
// Purpose  : Two-stage issue/execute unit: forwarding register file feeding an
//            8-op ALU with an iterative shift-add multiplier.
// Revision : 1.0
// ============================================================================
module regalu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int A0_IDX     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  we,
    input  logic                  alu_src,
    input  logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  eq,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int c_NREG = 1 << ADDR_WIDTH;
    localparam int c_SHW  = $clog2(DATA_WIDTH);
    localparam int c_CNTW = c_SHW + 1;
    localparam logic [ADDR_WIDTH-1:0] c_A0 = ADDR_WIDTH'(A0_IDX);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLL = 3'b101;
    localparam logic [2:0] c_OP_SLT = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_WIDTH-1:0] r_regs [c_NREG];

    // Execute stage; op1/op2 double as the multiplicand/multiplier shifters.
    logic                  r_ex_valid;
    logic [DATA_WIDTH-1:0] r_ex_op1;
    logic [DATA_WIDTH-1:0] r_ex_op2;
    logic [2:0]            r_ex_ctrl;
    logic [ADDR_WIDTH-1:0] r_ex_rd;
    logic                  r_ex_we;
    logic                  r_ex_eq;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [c_CNTW-1:0]     r_cnt;

    logic [DATA_WIDTH-1:0] r_alu_out;
    logic                  r_eq;
    logic                  r_out_valid;

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_issue_mul;
    logic                  w_mul_last;
    logic                  w_done;
    logic                  w_wb_en;
    logic                  w_ext_en;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2_reg;
    logic [DATA_WIDTH-1:0] w_op2;

    assign w_busy      = (r_state == S_MUL_RUN);
    assign w_accept    = in_valid && !w_busy;
    assign w_issue_mul = w_accept && (alu_ctrl == c_OP_MUL);

    assign in_ready  = !w_busy;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign eq        = r_eq;
    assign a0        = r_regs[c_A0];

    always_comb begin
        w_state_next = r_state;
        w_mul_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue_mul) begin
                    w_state_next = S_MUL_RUN;
                end
            end
            S_MUL_RUN: begin
                if (r_cnt == c_CNTW'(1)) begin
                    w_mul_last   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_acc_next = r_acc + (r_ex_op2[0] ? r_ex_op1 : '0);

    always_comb begin
        w_alu = '0;
        case (r_ex_ctrl)
            c_OP_ADD: w_alu = r_ex_op1 + r_ex_op2;
            c_OP_SUB: w_alu = r_ex_op1 - r_ex_op2;
            c_OP_AND: w_alu = r_ex_op1 & r_ex_op2;
            c_OP_OR:  w_alu = r_ex_op1 | r_ex_op2;
            c_OP_XOR: w_alu = r_ex_op1 ^ r_ex_op2;
            c_OP_SLL: w_alu = r_ex_op1 << r_ex_op2[c_SHW-1:0];
            c_OP_SLT: w_alu = {{(DATA_WIDTH-1){1'b0}},
                               ($signed(r_ex_op1) < $signed(r_ex_op2))};
            default:  w_alu = '0;
        endcase
    end

    assign w_done   = r_ex_valid || w_mul_last;
    assign w_result = w_mul_last ? w_acc_next : w_alu;
    assign w_wb_en  = w_done && r_ex_we && (r_ex_rd != '0);
    assign w_ext_en = ext_we && (ext_addr != '0);

    // Operand priority: completing pipeline result, then same-edge preload, then file.
    always_comb begin
        w_op1 = r_regs[rs1];
        if (w_wb_en && (rs1 == r_ex_rd)) begin
            w_op1 = w_result;
        end else if (w_ext_en && (rs1 == ext_addr)) begin
            w_op1 = ext_wd;
        end

        w_op2_reg = r_regs[rs2];
        if (w_wb_en && (rs2 == r_ex_rd)) begin
            w_op2_reg = w_result;
        end else if (w_ext_en && (rs2 == ext_addr)) begin
            w_op2_reg = ext_wd;
        end

        w_op2 = alu_src ? imm : w_op2_reg;
    end

    // Pipeline write is placed last so it overrides a same-address preload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ext_en) begin
                r_regs[ext_addr] <= ext_wd;
            end
            if (w_wb_en) begin
                r_regs[r_ex_rd] <= w_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
            r_ex_ctrl  <= c_OP_ADD;
            r_ex_rd    <= '0;
            r_ex_we    <= 1'b0;
            r_ex_eq    <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            r_ex_valid <= 1'b0;
            if (w_accept) begin
                r_ex_valid <= (alu_ctrl != c_OP_MUL);
                r_ex_op1   <= w_op1;
                r_ex_op2   <= w_op2;
                r_ex_ctrl  <= alu_ctrl;
                r_ex_rd    <= rd;
                r_ex_we    <= we;
                r_ex_eq    <= (w_op1 == w_op2);
                if (w_issue_mul) begin
                    r_acc <= '0;
                    r_cnt <= c_CNTW'(DATA_WIDTH);
                end
            end else if (w_busy) begin
                r_acc    <= w_acc_next;
                r_ex_op1 <= r_ex_op1 << 1;
                r_ex_op2 <= r_ex_op2 >> 1;
                r_cnt    <= r_cnt - c_CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out   <= '0;
            r_eq        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                r_alu_out <= w_result;
                r_eq      <= r_ex_eq;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regalu_pipe.sv
`default_nettype none
// Testbench for regalu_pipe: directed scenarios plus randomized traffic checked
// against a sequential architectural model of the register file and ALU.
module tb_regalu_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int A0 = 10;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] rs1, rs2, rd;
    logic          we;
    logic          alu_src;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] imm;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wd;
    logic          out_valid;
    logic [DW-1:0] alu_out;
    logic          eq;
    logic          busy;
    logic [DW-1:0] a0;

    regalu_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A0_IDX(A0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .we(we), .alu_src(alu_src),
        .alu_ctrl(alu_ctrl), .imm(imm), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wd(ext_wd), .out_valid(out_valid), .alu_out(alu_out), .eq(eq),
        .busy(busy), .a0(a0)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SLL = 3'd5, SLT = 3'd6, MUL = 3'd7;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m [NR];
    bit            pend;
    logic [DW-1:0] pend_res;
    logic          pend_eq;
    logic [AW-1:0] pend_rd;
    logic          pend_we;
    logic [DW-1:0] mul_res;
    logic          mul_eq;
    logic [AW-1:0] mul_rd;
    logic          mul_we;

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] c,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (c)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            OR_:     return a | b;
            XOR_:    return a ^ b;
            SLL:     return a << (b % DW);
            SLT:     return ($signed(a) < $signed(b)) ? DW'(1) : '0;
            default: return a * b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input int d, input int s1, input int s2,
                         input bit w, input bit src, input logic [DW-1:0] im);
        in_valid = 1'b1;
        alu_ctrl = c;
        rd       = AW'(d);
        rs1      = AW'(s1);
        rs2      = AW'(s2);
        we       = w;
        alu_src  = src;
        imm      = im;
    endtask

    task automatic ext_wr(input int addr, input logic [DW-1:0] d);
        ext_we   = 1'b1;
        ext_addr = AW'(addr);
        ext_wd   = d;
    endtask

    // One clock: model the edge (preload, then retiring op wins), check the
    // retiring op's outputs, and queue whatever was issued this cycle.
    task automatic step();
        logic [DW-1:0] nm [NR];
        logic [DW-1:0] o1, o2;
        bit acc;
        nm = m;
        if (ext_we && ext_addr != '0) nm[ext_addr] = ext_wd;
        if (pend && pend_we && pend_rd != '0) nm[pend_rd] = pend_res;
        acc = in_valid;
        o1 = '0;
        o2 = '0;
        if (acc) begin
            chk_bit("in_ready", in_ready, 1'b1);
            o1 = nm[rs1];
            o2 = alu_src ? imm : nm[rs2];
        end
        @(posedge clk);
        #1;
        m = nm;
        chk_bit("out_valid", out_valid, pend);
        if (pend) begin
            chk("alu_out", alu_out, pend_res);
            chk_bit("eq", eq, pend_eq);
        end
        chk("a0", a0, m[A0]);
        pend = 1'b0;
        if (acc) begin
            if (alu_ctrl == MUL) begin
                mul_res = ref_alu(MUL, o1, o2);
                mul_eq  = (o1 == o2);
                mul_rd  = rd;
                mul_we  = we;
            end else begin
                pend     = 1'b1;
                pend_res = ref_alu(alu_ctrl, o1, o2);
                pend_eq  = (o1 == o2);
                pend_rd  = rd;
                pend_we  = we;
            end
        end
        in_valid = 1'b0;
        ext_we   = 1'b0;
    endtask

    // Runs the multiply that step() just accepted, holding a competing request
    // high the whole time; abort_at > 0 asserts reset after that many cycles.
    task automatic mul_wait(input int abort_at);
        bit aborted;
        aborted = 1'b0;
        issue(ADD, 9, 1, 2, 1'b1, 1'b0, '0);
        for (int k = 1; k <= DW; k++) begin
            @(posedge clk);
            #1;
            if (k < DW) begin
                chk_bit("mul_busy", busy, 1'b1);
                chk_bit("mul_in_ready", in_ready, 1'b0);
                chk_bit("mul_out_valid", out_valid, 1'b0);
                chk("mul_a0", a0, m[A0]);
                if (k == abort_at) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst      = 1'b0;
                    in_valid = 1'b0;
                    for (int i = 0; i < NR; i++) m[i] = '0;
                    chk_bit("rst_busy", busy, 1'b0);
                    chk_bit("rst_out_valid", out_valid, 1'b0);
                    chk("rst_alu_out", alu_out, '0);
                    chk_bit("rst_eq", eq, 1'b0);
                    chk("rst_a0", a0, '0);
                    chk_bit("rst_in_ready", in_ready, 1'b1);
                    aborted = 1'b1;
                    break;
                end
            end else begin
                chk_bit("mul_done_valid", out_valid, 1'b1);
                chk_bit("mul_done_busy", busy, 1'b0);
                chk_bit("mul_done_ready", in_ready, 1'b1);
                chk("mul_result", alu_out, mul_res);
                chk_bit("mul_eq", eq, mul_eq);
                if (mul_we && mul_rd != '0) m[mul_rd] = mul_res;
                chk("mul_done_a0", a0, m[A0]);
            end
        end
        if (!aborted) in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; we = 1'b0;
        alu_src = 1'b0; alu_ctrl = ADD; imm = '0; ext_we = 1'b0; ext_addr = '0;
        ext_wd = '0; pend = 1'b0;
        for (int i = 0; i < NR; i++) m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_alu_out", alu_out, '0);
        chk_bit("reset_eq", eq, 1'b0);
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_in_ready", in_ready, 1'b1);
        chk("reset_a0", a0, '0);
        rst = 1'b0;

        // Preload, dependent ADD/SUB back-to-back through forwarding.
        ext_wr(1, 5); step();
        ext_wr(2, 7); step();
        issue(ADD, 3, 1, 2, 1, 0, '0); step();
        issue(SUB, 4, 3, 1, 1, 0, '0); step();
        chk("t1_add", alu_out, 12);
        step();
        chk("t1_sub", alu_out, 7);
        issue(ADD, 0, 4, 0, 0, 0, '0); step(); step();
        chk("t1_x4", alu_out, 7);

        // Immediate wrap-around into a0.
        issue(ADD, 10, 0, 0, 1, 1, 32'hFFFF_FFFF); step();
        issue(ADD, 10, 10, 0, 1, 1, 1); step();
        chk("t2_addi", alu_out, 32'hFFFF_FFFF);
        chk("t2_a0_max", a0, 32'hFFFF_FFFF);
        step();
        chk("t2_wrap", alu_out, 0);
        chk("t2_a0_wrap", a0, 0);
        chk_bit("t2_eq", eq, 1'b0);

        // Signed compare and shift amount masking.
        ext_wr(1, 3); step();
        ext_wr(2, 32'hFFFF_FFFC); step();
        issue(SLT, 5, 1, 2, 1, 0, '0); step();
        issue(SLT, 5, 2, 1, 1, 0, '0); step();
        chk("t3_slt_pos_neg", alu_out, 0);
        issue(SLL, 11, 1, 0, 1, 1, 33); step();
        chk("t3_slt_neg_pos", alu_out, 1);
        step();
        chk("t3_sll33", alu_out, 6);

        // Multiply with held request, then a dependent ADD.
        ext_wr(1, 123); step();
        ext_wr(2, 456); step();
        issue(MUL, 6, 1, 2, 1, 0, '0); step();
        mul_wait(0);
        chk("t4_mul", alu_out, 56088);
        issue(ADD, 12, 6, 0, 1, 1, '0); step(); step();
        chk("t4_dep_add", alu_out, 56088);
        issue(ADD, 0, 9, 0, 0, 0, '0); step(); step();

        // Reset in the middle of a multiply.
        issue(MUL, 6, 1, 2, 1, 0, '0); step();
        mul_wait(10);
        repeat (3) step();
        issue(ADD, 0, 6, 0, 0, 0, '0); step(); step();
        chk("t5_x6", alu_out, 0);

        // Same-edge write conflicts and x0 writes.
        issue(ADD, 7, 0, 0, 1, 1, 9); step();
        ext_wr(7, 1); issue(ADD, 9, 0, 0, 1, 1, 4); step();
        ext_wr(8, 2); step();
        ext_wr(0, 55); issue(ADD, 0, 0, 0, 1, 1, 77); step(); step();
        issue(ADD, 0, 7, 0, 0, 0, '0); step(); step();
        chk("t6_x7", alu_out, 9);
        issue(ADD, 0, 8, 0, 0, 0, '0); step(); step();
        chk("t6_x8", alu_out, 2);
        issue(ADD, 0, 9, 0, 0, 0, '0); step(); step();
        chk("t6_x9", alu_out, 4);
        issue(ADD, 0, 0, 0, 0, 0, '0); step(); step();
        chk("t6_x0", alu_out, 0);

        // Randomized traffic.
        for (int i = 1; i < 16; i++) begin
            ext_wr(i, $urandom); step();
        end
        for (int it = 0; it < 200; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                issue(MUL, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      $urandom);
                step();
                mul_wait(-1);
            end else begin
                if (r < 85) begin
                    issue(3'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom);
                end
                if ($urandom_range(0, 2) == 0) ext_wr(int'($urandom_range(0, 15)), $urandom);
                step();
            end
        end
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
